// File: rtl/button_event_decoder_pkg.sv
// Shared button event types and default timing, also imported by the control FSM.
// Defaults assume a 100 MHz clock: 1 s long press, 200 ms auto-repeat.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESSED      = 2'd1,
    LONG_HELD    = 2'd2,
    WAIT_RELEASE = 2'd3
  } btn_state_t;

  localparam int CLK_FREQ_HZ           = 100_000_000;
  localparam int LONG_CYCLES_DEFAULT   = CLK_FREQ_HZ;      // 1 s
  localparam int REPEAT_CYCLES_DEFAULT = CLK_FREQ_HZ / 5;  // 200 ms
  localparam int CNT_W_DEFAULT         = 27;

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/short/long/repeat pulses.
// All outputs registered (one cycle after the sampling edge); no backpressure, pulses are fire-and-forget.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT,
  parameter bit ACTIVE_HIGH   = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic clean,
  input  logic enable,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             pressed;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  assign pressed = (clean == ACTIVE_HIGH);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pressed_d = pressed;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pressed && !pressed_q) begin
          if (enable) begin
            state_d = PRESSED;
            press_d = 1'b1;
            count_d = '0;
          end else begin
            state_d = WAIT_RELEASE;
          end
        end
      end
      PRESSED: begin
        // Release beats the long threshold when both land on the same edge.
        if (!enable) begin
          state_d = WAIT_RELEASE;
        end else if (!pressed) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (count_q == LONG_LAST) begin
          long_d  = 1'b1;
          count_d = '0;
          state_d = LONG_HELD;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (!enable) begin
          state_d = WAIT_RELEASE;
        end else if (!pressed) begin
          state_d = IDLE;
        end else if (count_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          count_d  = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (!pressed) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // A level already held through reset must be released before it can count as a press.
      state_q   <= pressed ? WAIT_RELEASE : IDLE;
      count_q   <= '0;
      pressed_q <= pressed;
      press_q   <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse  = press_q;
  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign held         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG=8, REPEAT=4.
module tb_button_event_decoder;

  logic clock = 1'b0;
  logic reset;
  logic clean;
  logic enable;
  logic press_pulse, short_pulse, long_pulse, repeat_pulse, held;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected/observed output vector order: {press, short, long, repeat, held}
  typedef struct {
    logic       clean;
    logic       enable;
    logic       reset;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  button_event_decoder #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (4),
    .ACTIVE_HIGH  (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clean       (clean),
    .enable      (enable),
    .press_pulse (press_pulse),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  always #5 clock = ~clock;

  task automatic add(input logic c, input logic e, input logic r, input logic [4:0] x, input string nm);
    vec_t v;
    v.clean = c; v.enable = e; v.reset = r; v.exp = x; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive inputs, let one rising edge sample them, then compare 1 time unit later.
  task automatic apply(input logic c, input logic e, input logic r, input logic [4:0] x, input string nm);
    logic [4:0] got;
    clean  = c;
    enable = e;
    reset  = r;
    @(posedge clock);
    #1;
    got = {press_pulse, short_pulse, long_pulse, repeat_pulse, held};
    n_cmp++;
    if (got !== x) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (press,short,long,repeat,held)", nm, got, x);
    end
  endtask

  // Press at j=0, release sampled at j=rel; optional reset pulse at j=rst_at.
  task automatic hold_seq(input int rel, input int rst_at, input string nm);
    logic [4:0] x;
    for (int j = 0; j <= rel; j++) begin
      if (rst_at >= 0 && j >= rst_at)  x = 5'b00000;
      else if (j == rel)               x = (rel <= 8) ? 5'b01000 : 5'b00000;
      else if (j == 0)                 x = 5'b10001;
      else if (j == 8)                 x = 5'b00101;
      else if (j > 8 && (j - 8) % 4 == 0) x = 5'b00011;
      else                             x = 5'b00001;
      apply(j < rel, 1'b1, j == rst_at, x, $sformatf("%s_j%0d", nm, j));
    end
    apply(1'b0, 1'b1, 1'b0, 5'b00000, {nm, "_after"});
  endtask

  initial begin
    clean = 1'b0; enable = 1'b1; reset = 1'b1;

    // Reset with button released, then a 3-cycle short press.
    add(0, 1, 1, 5'b00000, "rst_idle");
    add(0, 1, 0, 5'b00000, "idle");
    add(1, 1, 0, 5'b10001, "sp_press");
    add(1, 1, 0, 5'b00001, "sp_hold1");
    add(1, 1, 0, 5'b00001, "sp_hold2");
    add(0, 1, 0, 5'b01000, "sp_short");
    add(0, 1, 0, 5'b00000, "sp_quiet");
    // Button held through reset: no edge, no pulses until a fresh press.
    add(1, 1, 1, 5'b00000, "rh_reset");
    for (int i = 0; i < 4; i++) add(1, 1, 0, 5'b00000, "rh_hold");
    add(0, 1, 0, 5'b00000, "rh_release");
    add(0, 1, 0, 5'b00000, "rh_idle");
    add(1, 1, 0, 5'b10001, "rh_press2");
    add(0, 1, 0, 5'b01000, "rh_short2");
    // Enable dropped mid-press, re-enabled while still held: no re-arm.
    add(1, 1, 0, 5'b10001, "en_press");
    for (int i = 0; i < 3; i++) add(1, 1, 0, 5'b00001, "en_hold");
    add(1, 0, 0, 5'b00000, "en_drop");
    add(1, 0, 0, 5'b00000, "en_off");
    for (int i = 0; i < 15; i++) add(1, 1, 0, 5'b00000, "en_rearm");
    add(0, 1, 0, 5'b00000, "en_release");
    // Press while disabled in IDLE: silent, including release.
    add(1, 0, 0, 5'b00000, "dis_press");
    add(1, 0, 0, 5'b00000, "dis_hold");
    add(1, 1, 0, 5'b00000, "dis_reen");
    add(0, 1, 0, 5'b00000, "dis_release");
    add(1, 1, 0, 5'b10001, "dis_press2");
    add(0, 1, 0, 5'b01000, "dis_short2");
    add(0, 1, 0, 5'b00000, "dis_quiet");

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].clean, vecs[i].enable, vecs[i].reset, vecs[i].exp, vecs[i].name);

    // Release sampled on the long threshold edge: short wins.
    hold_seq(8, -1, "thresh");
    // One cycle short of the threshold.
    hold_seq(7, -1, "pre_thresh");
    // Long hold with two repeats, silent release.
    hold_seq(18, -1, "long");
    // Release on a repeat edge suppresses the repeat.
    hold_seq(12, -1, "rep_edge");
    // Reset in the middle of a long hold, then release and press normally.
    hold_seq(14, 10, "mid_rst");
    apply(1, 1, 0, 5'b10001, "mid_rst_press");
    apply(1, 1, 0, 5'b00001, "mid_rst_hold");
    apply(0, 1, 0, 5'b01000, "mid_rst_short");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced level from the input debouncer and converts it into one-cycle event pulses: press, short release, long press, and auto-repeat while held.
- Sits between debounced push-button inputs and the anti-theft control FSM, so the control logic sees discrete events instead of levels.
- Timing is defined in clock cycles; at 100 MHz the defaults give a 1 s long press and a 200 ms repeat interval.

Parameters:
- LONG_CYCLES, 100_000_000, cycles of continuous hold before long_pulse; must be at least 2.
- REPEAT_CYCLES, 20_000_000, cycles between long_pulse and the first repeat_pulse, and between successive repeat_pulses; must be at least 2.
- CNT_W, 27, counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).
- ACTIVE_HIGH, 1, 1: clean=1 means pressed; 0: clean=0 means pressed.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- clean  in  1  debounced button level, synchronous to clock.
- enable  in  1  event generation enable.
- press_pulse  out  1  one-cycle pulse on press.
- short_pulse  out  1  one-cycle pulse on release before the long threshold.
- long_pulse  out  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat_pulse  out  1  one-cycle periodic pulse while held after long_pulse.
- held  out  1  high while in PRESSED or LONG_HELD.

Behaviour:
- pressed = clean XNOR ACTIVE_HIGH. All outputs are registered.
- Reset: all outputs 0; count 0.
  - pressed_q loads the current pressed value, so a level held through reset produces no edge.
  - State goes to WAIT_RELEASE if pressed is 1 during reset, else IDLE.
- States: IDLE, PRESSED, LONG_HELD, WAIT_RELEASE. Pulse outputs default to 0 every cycle.
- IDLE:
  - At edge k with pressed=1, pressed_q=0, enable=1: go to PRESSED, press_pulse=1 for the cycle after edge k, count=0.
  - Pressed edge with enable=0: go to WAIT_RELEASE, no pulse.
- PRESSED, at each edge, first matching rule wins:
  - (a) enable=0: go to WAIT_RELEASE, no pulse.
  - (b) pressed=0: short_pulse=1, go to IDLE.
  - (c) count==LONG_CYCLES-1: long_pulse=1, count=0, go to LONG_HELD.
  - (d) otherwise count+1.
  - Net timing: long_pulse asserts exactly LONG_CYCLES cycles after press_pulse.
  - Release sampled on the threshold edge gives short_pulse only; release wins.
- LONG_HELD, at each edge:
  - (a) enable=0: go to WAIT_RELEASE.
  - (b) pressed=0: go to IDLE, no pulse.
  - (c) count==REPEAT_CYCLES-1: repeat_pulse=1, count=0.
  - (d) otherwise count+1.
  - The first repeat_pulse comes REPEAT_CYCLES cycles after long_pulse, then every REPEAT_CYCLES cycles.
  - Release on a repeat edge: no repeat_pulse.
- WAIT_RELEASE: pressed=0 goes to IDLE; no pulses. Re-asserting enable while still held does not re-arm.
- pressed_q <= pressed every non-reset edge.
- held = (state==PRESSED || state==LONG_HELD), registered with state.
- Pulses are mutually exclusive; at most one asserts per cycle.
- Counter never wraps: it is cleared on every transition into PRESSED or LONG_HELD and bounded by the thresholds.
- Reset mid-hold: outputs 0 after the reset edge; behaviour then follows the reset rule.

Decomposition:
- Shared package (shared with the control FSM):
  - state typedef: IDLE, PRESSED, LONG_HELD, WAIT_RELEASE.
  - default timing constants: 100 MHz clock, 1 s long press, 200 ms repeat.
- No sub-module; edge detection and counter stay inline in the single FSM module.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4, ACTIVE_HIGH=1):
- Reset with clean=0, then clean=1 sampled at edge k, held 3 cycles, clean=0 at edge k+3 -> press_pulse after edge k, short_pulse after edge k+3, held high during cycles k..k+2, no long_pulse/repeat_pulse.
- clean=1 at edge k, released at edge k+18 -> press_pulse @k, long_pulse @k+8, repeat_pulse @k+12 and @k+16, nothing at release, held=0 after k+18.
- clean=1 at k, clean=0 sampled at k+8 -> short_pulse @k+8, no long_pulse.
- clean=1 throughout reset, release 5 cycles later, press again -> no pulses until the second press; press_pulse on the second press.
- Press at k, enable=0 at k+4, enable=1 at k+6, hold to k+20 -> no long_pulse/repeat_pulse, held=0 from k+4; enable=0 in IDLE during a press -> no pulses, no short_pulse on release.
- Reset asserted at k+10 of a long hold -> all outputs 0 after the reset edge, state WAIT_RELEASE; release -> IDLE; next press gives press_pulse normally.
